mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits.
REQ-002 Parameter TIMEOUT, default 64, maximum cycles to wait for mul_done before an error response.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 r0_valid / r1_valid  input  1  requester 0 / 1 holds a pending multiply.
REQ-006 r0_a, r0_b / r1_a, r1_b  input  WIDTH  signed two's-complement operands for requester 0 / 1.
REQ-007 r0_ready / r1_ready  output  1  request accepted this cycle (handshake = valid & ready).
REQ-008 mul_start  output  1  one-cycle start pulse to the shared sequential multiplier.
REQ-009 mul_a, mul_b  output  WIDTH  operands presented to the multiplier.
REQ-010 mul_done  input  1  multiplier product valid (one-cycle pulse).
REQ-011 mul_product  input  2*WIDTH  signed multiplier result.
REQ-012 rsp_valid  output  1  response held for the requester.
REQ-013 rsp_ready  input  1  response consumer accepts.
REQ-014 rsp_id  output  1  index of the requester that owns the response.
REQ-015 rsp_product  output  2*WIDTH  captured product.
REQ-016 rsp_err  output  1  response was produced by timeout, not by mul_done.

Function
REQ-017 FSM states SHALL be IDLE, START, BUSY, RESP.
REQ-018 IDLE: if any rX_valid, the arbiter asserts exactly one rX_ready combinationally, latches that requester's operands and id, and moves to START; otherwise it stays in IDLE.
REQ-019 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of history.
REQ-020 last_grant SHALL update only on an accepted handshake.
REQ-021 r0_ready and r1_ready SHALL be 0 in every state other than IDLE.
REQ-022 START: mul_start=1 for exactly one cycle with mul_a/mul_b equal to the latched operands; clear the timeout counter; go to BUSY.
REQ-023 mul_a/mul_b SHALL hold the latched operands from START until the next acceptance.
REQ-024 BUSY, mul_done=1: capture mul_product into rsp_product, set rsp_err=0, go to RESP.
REQ-025 BUSY, no mul_done: increment the counter; when it reaches TIMEOUT-1, set rsp_product=0 and rsp_err=1, and go to RESP.
REQ-026 If mul_done and the timeout coincide, mul_done SHALL win (rsp_err=0).
REQ-027 RESP: rsp_valid=1 with rsp_id, rsp_product and rsp_err stable; on rsp_ready go to IDLE; otherwise hold.
REQ-028 rsp_valid SHALL be 0 outside RESP; rsp_ready outside RESP is ignored.
REQ-029 mul_done outside BUSY SHALL be ignored without any state change.
REQ-030 Latency: acceptance in cycle T gives mul_start in T+1; mul_done in cycle D gives rsp_valid in D+1.
REQ-031 A new request SHALL NOT be accepted in the same cycle a response completes; the earliest next acceptance is the following cycle in IDLE.

Reset
REQ-032 While rst=0: state=IDLE; last_grant=1 (requester 0 wins first tie); counter=0; mul_start=0; mul_a=mul_b=0; rsp_valid=0, rsp_id=0, rsp_product=0, rsp_err=0; r0_ready=r1_ready=0 while rst is low.
REQ-033 Reset asserted mid-operation (START/BUSY/RESP) SHALL abort the transaction; after release no response for it is produced, and a late mul_done is ignored per REQ-029.

Verification
REQ-034 Single request: r0 a=3, b=-5; model returns -15 after 16 cycles -> r0_ready at T, mul_start at T+1, rsp_valid with id=0, product=-15, err=0.
REQ-035 Simultaneous requests after reset: r0 (2,7) and r1 (-4,-4) held valid -> r0 served first (14), then r1 (16); each r1_ready/r0_ready is a single-cycle pulse.
REQ-036 Fairness: both held valid for 6 transactions -> grant ids alternate 0,1,0,1,0,1.
REQ-037 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, no new ready, no mul_start; after rsp_ready, next accept occurs one cycle later.
REQ-038 Timeout: model never pulses mul_done, TIMEOUT=8 -> rsp_valid with product=0, err=1, 8 cycles after mul_start; stray mul_done in RESP has no effect.
REQ-039 Reset in BUSY, then release: outputs at reset values; a delayed mul_done produces no response; the next request completes normally.

Source files
------------

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one sequential multiplier between two requesters.
// A requester is accepted in IDLE, its operands go to the multiplier with a
// one-cycle start pulse, and the product (or a timeout error) is held as a
// response until the consumer takes it.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   r0_valid/a/b, r0_ready   requester 0 handshake and signed operands
//   r1_valid/a/b, r1_ready   requester 1 handshake and signed operands
//   mul_start, mul_a, mul_b  start pulse and operands to the multiplier
//   mul_done, mul_product    product-valid pulse and signed product from it
//   rsp_valid, rsp_ready     response handshake
//   rsp_id, rsp_product      owning requester and captured product
//   rsp_err                  response was produced by timeout
module mult_arbiter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 r0_valid,
    input  logic [WIDTH-1:0]     r0_a,
    input  logic [WIDTH-1:0]     r0_b,
    output logic                 r0_ready,
    input  logic                 r1_valid,
    input  logic [WIDTH-1:0]     r1_a,
    input  logic [WIDTH-1:0]     r1_b,
    output logic                 r1_ready,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_product,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_product,
    output logic                 rsp_err
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

    state_t          state, state_nxt;
    logic            last_grant, last_grant_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            owner, owner_nxt;
    logic            grant_id;
    logic            accept;
    logic [WIDTH-1:0] mul_a_nxt, mul_b_nxt;
    logic            rsp_id_nxt, rsp_err_nxt;
    logic [PW-1:0]   rsp_product_nxt;

    // Round-robin pick: on a tie favour the requester not granted last.
    always_comb begin
        grant_id = 1'b0;
        if (r0_valid && r1_valid) begin
            grant_id = ~last_grant;
        end else if (r1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Ready is combinational from valid; gated by rst so nothing is accepted during reset.
    assign accept   = rst && (state == IDLE) && (r0_valid || r1_valid);
    assign r0_ready = accept && !grant_id;
    assign r1_ready = accept && grant_id;

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        last_grant_nxt  = last_grant;
        cnt_nxt         = cnt;
        owner_nxt       = owner;
        mul_a_nxt       = mul_a;
        mul_b_nxt       = mul_b;
        rsp_id_nxt      = rsp_id;
        rsp_product_nxt = rsp_product;
        rsp_err_nxt     = rsp_err;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt      = START;
                    last_grant_nxt = grant_id;
                    owner_nxt      = grant_id;
                    mul_a_nxt      = grant_id ? r1_a : r0_a;
                    mul_b_nxt      = grant_id ? r1_b : r0_b;
                end
            end
            START: begin
                cnt_nxt   = '0;
                state_nxt = BUSY;
            end
            BUSY: begin
                // mul_done takes priority over a timeout landing in the same cycle.
                if (mul_done) begin
                    rsp_product_nxt = mul_product;
                    rsp_err_nxt     = 1'b0;
                    rsp_id_nxt      = owner;
                    state_nxt       = RESP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt_nxt == CNT_LAST) begin
                        rsp_product_nxt = '0;
                        rsp_err_nxt     = 1'b1;
                        rsp_id_nxt      = owner;
                        state_nxt       = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            cnt         <= '0;
            owner       <= 1'b0;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_product <= '0;
            rsp_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            cnt         <= cnt_nxt;
            owner       <= owner_nxt;
            mul_start   <= (state_nxt == START);
            mul_a       <= mul_a_nxt;
            mul_b       <= mul_b_nxt;
            rsp_valid   <= (state_nxt == RESP);
            rsp_id      <= rsp_id_nxt;
            rsp_product <= rsp_product_nxt;
            rsp_err     <= rsp_err_nxt;
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
module tb_mult_arbiter;
    localparam int unsigned W  = 16;
    localparam int unsigned PW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic r0_valid, r1_valid, r0_ready, r1_ready;
    logic [W-1:0] r0_a, r0_b, r1_a, r1_b, mul_a, mul_b;
    logic mul_start;
    logic mul_done = 1'b0;
    logic [PW-1:0] mul_product = '0;
    logic rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [PW-1:0] rsp_product;

    // Second instance with a short timeout.
    logic t_r0_valid, t_r0_ready, t_r1_ready, t_mul_start, t_mul_done;
    logic [W-1:0] t_r0_a, t_r0_b, t_mul_a, t_mul_b;
    logic [PW-1:0] t_mul_product;
    logic t_rsp_valid, t_rsp_ready, t_rsp_id, t_rsp_err;
    logic [PW-1:0] t_rsp_product;

    mult_arbiter #(.WIDTH(W), .TIMEOUT(64)) u_dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_a(r0_a), .r0_b(r0_b), .r0_ready(r0_ready),
        .r1_valid(r1_valid), .r1_a(r1_a), .r1_b(r1_b), .r1_ready(r1_ready),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .rsp_err(rsp_err)
    );

    mult_arbiter #(.WIDTH(W), .TIMEOUT(8)) u_to (
        .clk(clk), .rst(rst),
        .r0_valid(t_r0_valid), .r0_a(t_r0_a), .r0_b(t_r0_b), .r0_ready(t_r0_ready),
        .r1_valid(1'b0), .r1_a('0), .r1_b('0), .r1_ready(t_r1_ready),
        .mul_start(t_mul_start), .mul_a(t_mul_a), .mul_b(t_mul_b),
        .mul_done(t_mul_done), .mul_product(t_mul_product),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_id(t_rsp_id),
        .rsp_product(t_rsp_product), .rsp_err(t_rsp_err)
    );

    // Sequential multiplier model: product appears mul_lat cycles after mul_start.
    int unsigned mul_lat = 1;
    int unsigned m_left  = 0;
    int m_a = 0;
    int m_b = 0;
    always @(posedge clk) begin
        #1;
        mul_done = 1'b0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                mul_done    = 1'b1;
                mul_product = PW'(m_a * m_b);
            end
        end
        if (mul_start) begin
            m_left = mul_lat;
            m_a    = int'($signed(mul_a));
            m_b    = int'($signed(mul_b));
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
        t_r0_valid = 1'b0; t_rsp_ready = 1'b0; t_mul_done = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
    endtask

    typedef struct {
        logic        id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int unsigned lat;
        int          prod;
    } vec_t;

    vec_t vecs[5];

    // One request from a single requester, full handshake with latency checks.
    task automatic single_txn(input string tag, input logic id, input logic [W-1:0] a,
                              input logic [W-1:0] b, input int unsigned lat, input int prod);
        int   k;
        logic extra;
        mul_lat = lat;
        if (id) begin r1_valid = 1'b1; r1_a = a; r1_b = b; end
        else    begin r0_valid = 1'b1; r0_a = a; r0_b = b; end
        smp();
        chk({tag, " ready"}, id ? r1_ready : r0_ready, 1);
        chk({tag, " other_ready"}, id ? r0_ready : r1_ready, 0);
        cyc();
        r0_valid = 1'b0; r1_valid = 1'b0;
        smp();
        chk({tag, " mul_start"}, mul_start, 1);
        chk({tag, " mul_a"}, mul_a, a);
        chk({tag, " mul_b"}, mul_b, b);
        k = 0; extra = 1'b0;
        while (k < 200) begin
            cyc(); smp(); k++;
            if (rsp_valid) break;
            if (mul_start) extra = 1'b1;
        end
        chk({tag, " rsp_latency"}, k, lat + 1);
        chk({tag, " extra_start"}, extra, 0);
        chk({tag, " rsp_id"}, rsp_id, id);
        chk({tag, " rsp_product"}, int'(rsp_product), prod);
        chk({tag, " rsp_err"}, rsp_err, 0);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        smp();
        chk({tag, " rsp_cleared"}, rsp_valid, 0);
        cyc();
    endtask

    // Both requesters held valid: six grants must alternate starting with r0.
    task automatic test_fairness();
        int   gids[6];
        int   rids[6];
        int   rprod[6];
        int   ng, nr, last_rsp_c;
        logic rdy, prev_rdy, both, pulse_bad, gap_bad;
        do_reset();
        ng = 0; nr = 0; last_rsp_c = -10;
        prev_rdy = 1'b0; both = 1'b0; pulse_bad = 1'b0; gap_bad = 1'b0;
        r0_valid = 1'b1; r0_a = 16'd2; r0_b = 16'd7;
        r1_valid = 1'b1; r1_a = 16'hFFFC; r1_b = 16'hFFFC;
        rsp_ready = 1'b1; mul_lat = 2;
        for (int c = 0; c < 300 && nr < 6; c++) begin
            smp();
            rdy = r0_ready | r1_ready;
            if (r0_ready && r1_ready) both = 1'b1;
            if (rdy && prev_rdy) pulse_bad = 1'b1;
            if (rdy) begin
                if (ng < 6) gids[ng] = int'(r1_ready);
                ng++;
                if (nr > 0 && c != last_rsp_c + 1) gap_bad = 1'b1;
            end
            if (rsp_valid && rsp_ready) begin
                rids[nr]  = int'(rsp_id);
                rprod[nr] = int'(rsp_product);
                nr++;
                last_rsp_c = c;
            end
            prev_rdy = rdy;
            cyc();
        end
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
        chk("fair responses", nr, 6);
        chk("fair grants", ng, 6);
        for (int i = 0; i < 6 && i < nr && i < ng; i++) begin
            chk($sformatf("fair grant_id[%0d]", i), gids[i], i % 2);
            chk($sformatf("fair rsp_id[%0d]", i), rids[i], i % 2);
            chk($sformatf("fair product[%0d]", i), rprod[i], (i % 2) ? 16 : 14);
        end
        chk("fair both_ready", both, 0);
        chk("fair ready_pulse", pulse_bad, 0);
        chk("fair accept_gap", gap_bad, 0);
        cyc();
    endtask

    // Response held off for 10 cycles while r1 waits.
    task automatic test_backpressure();
        int   k;
        logic bad;
        logic s_id, s_err;
        logic [PW-1:0] s_prod;
        mul_lat = 3;
        r0_valid = 1'b1; r0_a = 16'd9; r0_b = 16'hFFFD;
        cyc();
        r0_valid = 1'b0;
        k = 0;
        while (k < 200) begin
            cyc(); smp(); k++;
            if (rsp_valid) break;
        end
        chk("bp rsp_product", int'(rsp_product), -27);
        s_id = rsp_id; s_err = rsp_err; s_prod = rsp_product;
        r1_valid = 1'b1; r1_a = 16'd1; r1_b = 16'd1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!rsp_valid || rsp_id != s_id || rsp_err != s_err || rsp_product != s_prod ||
                r0_ready || r1_ready || mul_start) bad = 1'b1;
            cyc(); smp();
        end
        chk("bp hold_stable", bad, 0);
        rsp_ready = 1'b1;
        chk("bp no_accept_on_complete", r1_ready, 0);
        cyc();
        rsp_ready = 1'b0;
        smp();
        chk("bp accept_next_cycle", r1_ready, 1);
        chk("bp rsp_dropped", rsp_valid, 0);
        cyc();
        r1_valid = 1'b0;
        k = 0;
        while (k < 200) begin
            cyc(); smp(); k++;
            if (rsp_valid) break;
        end
        chk("bp second_id", rsp_id, 1);
        chk("bp second_product", int'(rsp_product), 1);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
    endtask

    // Timeout, stray mul_done in RESP, and mul_done on the last BUSY cycle.
    task automatic test_timeout();
        int k;
        t_r0_valid = 1'b1; t_r0_a = 16'd5; t_r0_b = 16'd6;
        smp();
        chk("to ready", t_r0_ready, 1);
        chk("to r1_ready", t_r1_ready, 0);
        cyc();
        t_r0_valid = 1'b0;
        smp();
        chk("to mul_start", t_mul_start, 1);
        chk("to mul_a", t_mul_a, 5);
        chk("to mul_b", t_mul_b, 6);
        k = 0;
        while (k < 100) begin
            cyc(); smp(); k++;
            if (t_rsp_valid) break;
        end
        chk("to latency", k, 8);
        chk("to product", int'(t_rsp_product), 0);
        chk("to err", t_rsp_err, 1);
        chk("to id", t_rsp_id, 0);
        t_mul_product = 32'h1234_5678;
        t_mul_done = 1'b1;
        cyc();
        t_mul_done = 1'b0;
        smp();
        chk("to stray valid", t_rsp_valid, 1);
        chk("to stray err", t_rsp_err, 1);
        chk("to stray product", int'(t_rsp_product), 0);
        t_rsp_ready = 1'b1;
        cyc();
        t_rsp_ready = 1'b0;
        t_r0_valid = 1'b1; t_r0_a = 16'hFFF9; t_r0_b = 16'd6;
        cyc();
        t_r0_valid = 1'b0;
        smp();
        chk("tie mul_start", t_mul_start, 1);
        repeat (7) cyc();
        smp();
        chk("tie not_early", t_rsp_valid, 0);
        t_mul_product = 32'hFFFF_FFD6;
        t_mul_done = 1'b1;
        cyc();
        t_mul_done = 1'b0;
        smp();
        chk("tie valid", t_rsp_valid, 1);
        chk("tie err", t_rsp_err, 0);
        chk("tie product", int'(t_rsp_product), -42);
        t_rsp_ready = 1'b1;
        cyc();
        t_rsp_ready = 1'b0;
    endtask

    // Reset while BUSY: abort, ignore the late mul_done, then serve normally.
    task automatic test_reset_busy();
        logic bad;
        mul_lat = 10;
        r1_valid = 1'b1; r1_a = 16'd100; r1_b = 16'd3;
        cyc();
        r1_valid = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        r0_valid = 1'b1;
        smp();
        chk("rstb r0_ready", r0_ready, 0);
        chk("rstb rsp_valid", rsp_valid, 0);
        chk("rstb mul_a", mul_a, 0);
        chk("rstb mul_b", mul_b, 0);
        chk("rstb rsp_product", rsp_product, 0);
        chk("rstb rsp_id", rsp_id, 0);
        cyc();
        r0_valid = 1'b0;
        rst = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            smp();
            if (rsp_valid || mul_start) bad = 1'b1;
            cyc();
        end
        chk("rstb no_ghost_rsp", bad, 0);
        single_txn("rstb after", 1'b0, 16'd11, 16'd12, 4, 132);
    endtask

    // Random traffic against a transaction-level model.
    task automatic test_random(input int n);
        logic busy, start_due, wait_done, resp_pend, last, cid, g_any, g_id;
        logic [W-1:0] ca, cb;
        int cprod;
        do_reset();
        busy = 1'b0; start_due = 1'b0; wait_done = 1'b0; resp_pend = 1'b0; last = 1'b1;
        cid = 1'b0; ca = '0; cb = '0; cprod = 0;
        for (int c = 0; c < n; c++) begin
            r0_valid  = 1'($urandom_range(0, 1));
            r1_valid  = 1'($urandom_range(0, 1));
            r0_a = W'($urandom); r0_b = W'($urandom);
            r1_a = W'($urandom); r1_b = W'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            mul_lat   = $urandom_range(1, 6);
            smp();
            g_any = !busy && (r0_valid || r1_valid);
            g_id  = (r0_valid && r1_valid) ? !last : r1_valid;
            chk("rnd r0_ready", r0_ready, g_any && !g_id);
            chk("rnd r1_ready", r1_ready, g_any && g_id);
            chk("rnd mul_start", mul_start, start_due);
            if (start_due) begin
                chk("rnd mul_a", mul_a, ca);
                chk("rnd mul_b", mul_b, cb);
            end
            chk("rnd rsp_valid", rsp_valid, resp_pend);
            if (resp_pend) begin
                chk("rnd rsp_id", rsp_id, cid);
                chk("rnd rsp_product", int'(rsp_product), cprod);
                chk("rnd rsp_err", rsp_err, 0);
            end
            if (resp_pend && rsp_ready) begin resp_pend = 1'b0; busy = 1'b0; end
            if (wait_done && mul_done) begin wait_done = 1'b0; resp_pend = 1'b1; end
            if (start_due) begin start_due = 1'b0; wait_done = 1'b1; end
            if (g_any) begin
                busy = 1'b1; start_due = 1'b1; last = g_id; cid = g_id;
                ca = g_id ? r1_a : r0_a;
                cb = g_id ? r1_b : r0_b;
                cprod = int'($signed(ca)) * int'($signed(cb));
            end
            cyc();
        end
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (12) cyc();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 16'd3,    16'hFFFB, 16, -15};
        vecs[1] = '{1'b1, 16'h8000, 16'h8000, 3,  1073741824};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h8000, 1,  -1073709056};
        vecs[3] = '{1'b1, 16'hFFFF, 16'h0001, 5,  -1};
        vecs[4] = '{1'b0, 16'h0000, 16'h04D2, 2,  0};

        rst = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1;
        r0_a = 16'd1; r0_b = 16'd1; r1_a = 16'd1; r1_b = 16'd1;
        rsp_ready = 1'b0;
        t_r0_valid = 1'b0; t_r0_a = '0; t_r0_b = '0;
        t_mul_done = 1'b0; t_mul_product = '0; t_rsp_ready = 1'b0;
        smp();
        chk("reset r0_ready", r0_ready, 0);
        chk("reset r1_ready", r1_ready, 0);
        chk("reset mul_start", mul_start, 0);
        chk("reset mul_a", mul_a, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_id", rsp_id, 0);
        chk("reset rsp_product", rsp_product, 0);
        chk("reset rsp_err", rsp_err, 0);
        do_reset();

        for (int i = 0; i < 5; i++) begin
            single_txn($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b,
                       vecs[i].lat, vecs[i].prod);
        end

        test_fairness();
        test_backpressure();
        test_timeout();
        test_reset_busy();
        test_random(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
